aibnd_str_txdrv: RTL and testbench

- Transmit-side driver that feeds the strobe/IO pad path, the counterpart of the receive-side pad load.
- Accepts parallel words over a valid/ready handshake.
- Before a burst, emits a fixed alternating training preamble, then serializes each word LSB-first onto one pad data bit with an output-enable.
- Sits between the adapter TX datapath and the aibnd output buffer.

---
 rtl/aibnd_str_pkg.sv | 22 ++
 rtl/aibnd_str_shreg.sv | 28 ++
 rtl/aibnd_str_txdrv.sv | 162 ++++++++++++++++
 tb/tb_aibnd_str_txdrv.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aibnd_str_pkg.sv
// Shared types and constants for the aibnd strobe transmit driver.
// Optional parity feature is selected by the AIBND_STR_PARITY_EN macro.
package aibnd_str_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        SHIFT = 2'd2,
        PAR   = 2'd3
    } state_t;

    // First bit of the alternating training preamble.
    localparam logic PRE_FIRST_BIT = 1'b1;

    // Bit counter must reach WIDTH (data) and PREAMBLE_LEN-1 (preamble).
    function automatic int cnt_width(input int width, input int pre_len);
        int span;
        span = ((width + 1) > pre_len) ? (width + 1) : pre_len;
        return $clog2(span);
    endfunction

endpackage

// File: rtl/aibnd_str_shreg.sv
// WIDTH-bit load / shift-right register; sout is the current bit 0.
module aibnd_str_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] q;

    // Load has priority over shift; zeros are shifted in at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/aibnd_str_txdrv.sv
// Transmit pad driver: valid/ready word intake, alternating preamble at the
// start of a burst, LSB-first serialization onto pad_dout with pad_oe.
// Define AIBND_STR_PARITY_EN to append an even-parity bit after every word.
module aibnd_str_txdrv
    import aibnd_str_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int PREAMBLE_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drv_en,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             pad_dout,
    output logic             pad_oe,
    output logic             busy
);

    localparam int            CW       = cnt_width(WIDTH, PREAMBLE_LEN);
    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    cnt_inc;
    logic             last_bit;
    logic             word_end;
    logic             ready_state;
    logic             accept;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] shreg_din;
    logic             sout;
    logic             dout_nxt;
    logic             oe_nxt;
    logic             par_bit;

    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign last_bit = (state == SHIFT) && (cnt == BIT_LAST);

`ifdef AIBND_STR_PARITY_EN
    logic par_q;

    // Even parity of the word, captured alongside the word itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^tx_data;
        end
    end

    assign par_bit  = par_q;
    assign word_end = (state == PAR);
`else
    assign par_bit  = 1'b0;
    assign word_end = last_bit;
`endif

    assign ready_state = (state == IDLE) || word_end;
    assign tx_ready    = ~rst & drv_en & ready_state;
    assign accept      = tx_valid & tx_ready;
    assign busy        = (state != IDLE);

    aibnd_str_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (shreg_din),
        .sout  (sout)
    );

    // State, counter and registered pad outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pad_dout <= 1'b0;
            pad_oe   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pad_dout <= dout_nxt;
            pad_oe   <= oe_nxt;
        end
    end

    // Next state, counter, shift control and next pad values.
    // The pad bit is registered in the same edge the shifter advances, so the
    // shifter always holds the word one bit ahead of the pad. A back-to-back
    // word therefore puts bit 0 straight on the pad and loads the rest pre-shifted.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        load      = 1'b0;
        shift     = 1'b0;
        shreg_din = tx_data;
        dout_nxt  = 1'b0;
        oe_nxt    = 1'b0;

        if (word_end) begin
            cnt_nxt = '0;
            if (accept) begin
                state_nxt = SHIFT;
                load      = 1'b1;
                shreg_din = tx_data >> 1;
                dout_nxt  = tx_data[0];
                oe_nxt    = 1'b1;
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (accept) begin
                        state_nxt = PRE;
                        load      = 1'b1;
                        dout_nxt  = PRE_FIRST_BIT;
                        oe_nxt    = 1'b1;
                    end
                end
                PRE: begin
                    oe_nxt = 1'b1;
                    if (cnt == PRE_LAST) begin
                        state_nxt = SHIFT;
                        cnt_nxt   = '0;
                        shift     = 1'b1;
                        dout_nxt  = sout;
                    end else begin
                        dout_nxt = PRE_FIRST_BIT ^ cnt_inc[0];
                    end
                end
                SHIFT: begin
                    oe_nxt = 1'b1;
                    if (last_bit) begin
                        // Only reachable with parity enabled; otherwise word_end.
                        state_nxt = PAR;
                        cnt_nxt   = '0;
                        dout_nxt  = par_bit;
                    end else begin
                        shift    = 1'b1;
                        dout_nxt = sout;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aibnd_str_txdrv.sv
// Bench for aibnd_str_txdrv: queue-of-pad-beats model plus literal burst checks.
// Build with AIBND_STR_PARITY_EN to cover the parity variant.
module tb_aibnd_str_txdrv;

    localparam int WIDTH   = 8;
    localparam int PRE_LEN = 4;

`ifdef AIBND_STR_PARITY_EN
    localparam int          WLEN    = PRE_LEN + WIDTH + 1;
    localparam logic [31:0] E_A5    = 32'h154A;
    localparam logic [31:0] E_A5_3C = 32'h2A9478;
    localparam logic [31:0] E_0F    = 32'h15E0;
`else
    localparam int          WLEN    = PRE_LEN + WIDTH;
    localparam logic [31:0] E_A5    = 32'hAA5;
    localparam logic [31:0] E_A5_3C = 32'hAA53C;
    localparam logic [31:0] E_0F    = 32'hAF0;
`endif
    localparam int B2B_LEN = 2 * WLEN - PRE_LEN;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             drv_en   = 1'b1;
    logic             tx_valid = 1'b0;
    logic [WIDTH-1:0] tx_data  = '0;
    logic             tx_ready;
    logic             pad_dout;
    logic             pad_oe;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic exp_q[$];
    logic pad_log[$];
    int   cur_run = 0;
    int   max_run = 0;

    always #5 clk = ~clk;

    aibnd_str_txdrv #(
        .WIDTH        (WIDTH),
        .PREAMBLE_LEN (PRE_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .drv_en   (drv_en),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .pad_dout (pad_dout),
        .pad_oe   (pad_oe),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_log();
        logic [31:0] v;
        v = '0;
        foreach (pad_log[i]) v = {v[30:0], pad_log[i]};
        return v;
    endfunction

    // Model: queue of pad beats still to be shown; head is the beat on the pad now.
    always @(posedge clk or posedge rst) begin : model
        logic was_idle;
        logic ready;
        if (rst) begin
            exp_q.delete();
        end else begin
            was_idle = (exp_q.size() == 0);
            ready    = drv_en && (exp_q.size() <= 1);
            if (!was_idle) void'(exp_q.pop_front());
            if (tx_valid && ready) begin
                if (was_idle)
                    for (int i = 0; i < PRE_LEN; i++) exp_q.push_back(i % 2 == 0);
                for (int i = 0; i < WIDTH; i++) exp_q.push_back(tx_data[i]);
`ifdef AIBND_STR_PARITY_EN
                exp_q.push_back(^tx_data);
`endif
            end
        end
    end

    // Compare DUT against the model every cycle and log driven pad bits.
    always @(negedge clk) begin : compare
        logic e_oe;
        logic e_dout;
        e_oe   = (exp_q.size() != 0);
        e_dout = e_oe ? exp_q[0] : 1'b0;
        chk("pad_oe", pad_oe, e_oe);
        chk("pad_dout", pad_dout, e_dout);
        chk("busy", busy, e_oe);
        chk("tx_ready", tx_ready, drv_en && !rst && (exp_q.size() <= 1));
        if (pad_oe) begin
            pad_log.push_back(pad_dout);
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            cur_run = 0;
        end
    end

    task automatic clear_log();
        pad_log.delete();
        max_run = 0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d);
        logic r;
        int   n;
        n        = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        do begin
            @(negedge clk);
            r = tx_ready;
            @(posedge clk);
            n++;
        end while (!r && n < 100);
        chk("accept_in_time", r, 1);
        #2 tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        chk("idle_in_time", busy, 0);
        @(posedge clk);
        #2;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin : stim
        // 1: reset hold and idle with drv_en high
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("t1_tx_ready", tx_ready, 1);
        chk("t1_pad_oe", pad_oe, 0);
        chk("t1_busy", busy, 0);

        // 2: single word 0xA5
        clear_log();
        send_word(8'hA5);
        wait_idle();
        repeat (2) @(posedge clk);
        #2;
        chk("t2_bits", pack_log(), E_A5);
        chk("t2_len", pad_log.size(), WLEN);
        chk("t2_run", max_run, WLEN);

        // 3: back-to-back 0xA5, 0x3C
        clear_log();
        send_word(8'hA5);
        send_word(8'h3C);
        wait_idle();
        repeat (2) @(posedge clk);
        #2;
        chk("t3_bits", pack_log(), E_A5_3C);
        chk("t3_len", pad_log.size(), B2B_LEN);
        chk("t3_run", max_run, B2B_LEN);

        // 4: drv_en dropped during bit 3 with 0x3C pending
        clear_log();
        send_word(8'hA5);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        repeat (PRE_LEN + 3) @(posedge clk);
        #2 drv_en = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #2;
        chk("t4_tx_ready", tx_ready, 0);
        chk("t4_bits", pack_log(), E_A5);
        chk("t4_len", pad_log.size(), WLEN);
        tx_valid = 1'b0;
        drv_en   = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // 5: async reset during bit 5, then a fresh word 0x0F
        send_word(8'hA5);
        repeat (PRE_LEN + 5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_oe", pad_oe, 0);
        chk("t5_rst_dout", pad_dout, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", tx_ready, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        clear_log();
        send_word(8'h0F);
        wait_idle();
        repeat (2) @(posedge clk);
        #2;
        chk("t5_bits", pack_log(), E_0F);
        chk("t5_len", pad_log.size(), WLEN);

`ifdef AIBND_STR_PARITY_EN
        // 6: parity bits for 0xA5 (even) and 0x07 (odd)
        clear_log();
        send_word(8'hA5);
        wait_idle();
        #2;
        chk("t6_a5_bits", pack_log(), 32'h154A);
        chk("t6_a5_run", max_run, 13);
        clear_log();
        send_word(8'h07);
        wait_idle();
        #2;
        chk("t6_07_bits", pack_log(), 32'h15C1);
        chk("t6_07_run", max_run, 13);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
